// File: rtl/agg_pkg.sv
// rtl/agg_pkg.sv - shared types and constants for the rule-aggregation sequencer
package agg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } agg_state_t;

   localparam logic [15:0] Q15_MAX    = 16'd32767;
   localparam logic [31:0] Q15_HALF   = 32'd16384;
   localparam int          RULE_IDX_W = 4;
   localparam int          ACC_W      = 20;

   localparam logic [RULE_IDX_W-1:0] CORNER_IDX [4] = '{4'd0, 4'd2, 4'd6, 4'd8};

   // Saturation happens once on the final sum, never per accumulation step.
   function automatic logic [15:0] sat_q15(input logic [ACC_W-1:0] acc);
      return (acc > {{(ACC_W-16){1'b0}}, Q15_MAX}) ? Q15_MAX : acc[15:0];
   endfunction

endpackage

// File: rtl/agg_seq_ctrl_if.sv
// rtl/agg_seq_ctrl_if.sv - operand and result handshake bundle for agg_seq_ctrl
interface agg_seq_ctrl_if;

   logic        reg_mode;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
   logic [7:0]  g00, g01, g02, g10, g11, g12, g20, g21, g22;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] S_w;
   logic [15:0] S_wg;

   modport master (
      output reg_mode, in_valid,
      output w00, w01, w02, w10, w11, w12, w20, w21, w22,
      output g00, g01, g02, g10, g11, g12, g20, g21, g22,
      output out_ready,
      input  in_ready, out_valid, S_w, S_wg
   );

   modport slave (
      input  reg_mode, in_valid,
      input  w00, w01, w02, w10, w11, w12, w20, w21, w22,
      input  g00, g01, g02, g10, g11, g12, g20, g21, g22,
      input  out_ready,
      output in_ready, out_valid, S_w, S_wg
   );

endinterface

// File: rtl/g_pct_to_q15.sv
// rtl/g_pct_to_q15.sv - constant table mapping percent singletons to Q1.15
module g_pct_to_q15
   import agg_pkg::*;
(
   input  logic [7:0]  g,
   output logic [15:0] gq
);

   logic [15:0] lut [256];

   // Table is fully elaborated from constants so no divider reaches silicon.
   for (genvar i = 0; i < 256; i++) begin : g_lut
      if (i >= 100) begin : g_sat
         assign lut[i] = Q15_MAX;
      end else begin : g_cal
         assign lut[i] = 16'((i * 32767 + 50) / 100);
      end
   end

   assign gq = lut[g];

endmodule

// File: rtl/agg_seq_ctrl.sv
// rtl/agg_seq_ctrl.sv - sequential rule aggregator sharing one multiplier across rules
module agg_seq_ctrl
   import agg_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   agg_seq_ctrl_if.slave         bus,
   output logic                  busy,
   output logic [RULE_IDX_W-1:0] rule_idx
);

   agg_state_t            state, state_nxt;
   logic                  mode_q;
   logic [15:0]           w_q [9];
   logic [7:0]            g_q [9];
   logic [15:0]           w_in [9];
   logic [7:0]            g_in [9];
   logic [RULE_IDX_W-1:0] step, run_idx, last_step;
   logic [ACC_W-1:0]      acc_w, acc_wg, sum_w, sum_wg;
   logic [15:0]           w_sel, gq, prod_q15, s_w_q, s_wg_q;
   logic [7:0]            g_sel;
   logic [31:0]           prod_full;
   logic [16:0]           prod_shr;
   logic                  accept, last_rule;

   assign w_in = '{bus.w00, bus.w01, bus.w02, bus.w10, bus.w11, bus.w12, bus.w20, bus.w21, bus.w22};
   assign g_in = '{bus.g00, bus.g01, bus.g02, bus.g10, bus.g11, bus.g12, bus.g20, bus.g21, bus.g22};

   assign accept    = bus.in_valid && (state == IDLE);
   assign last_step = mode_q ? 4'd8 : 4'd3;
   assign last_rule = (step == last_step);
   assign run_idx   = mode_q ? step : CORNER_IDX[step[1:0]];

   always_comb begin
      w_sel = '0;
      g_sel = '0;
      for (int i = 0; i < 9; i++) begin
         if (run_idx == 4'(i)) begin
            w_sel = w_q[i];
            g_sel = g_q[i];
         end
      end
   end

   g_pct_to_q15 u_g_lut (
      .g  (g_sel),
      .gq (gq)
   );

   // Round-half-up then clamp; the 32-bit intermediate cannot wrap for 16x16 operands.
   assign prod_full = ({16'd0, w_sel} * {16'd0, gq}) + Q15_HALF;
   assign prod_shr  = 17'(prod_full >> 15);
   assign prod_q15  = (prod_shr > {1'b0, Q15_MAX}) ? Q15_MAX : prod_shr[15:0];

   assign sum_w  = acc_w  + {{(ACC_W-16){1'b0}}, w_sel};
   assign sum_wg = acc_wg + {{(ACC_W-16){1'b0}}, prod_q15};

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)        state_nxt = RUN;
         RUN:     if (last_rule)     state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q <= 1'b0;
         step   <= '0;
         acc_w  <= '0;
         acc_wg <= '0;
         s_w_q  <= '0;
         s_wg_q <= '0;
         for (int i = 0; i < 9; i++) begin
            w_q[i] <= '0;
            g_q[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mode_q <= bus.reg_mode;
                  step   <= '0;
                  acc_w  <= '0;
                  acc_wg <= '0;
                  for (int i = 0; i < 9; i++) begin
                     w_q[i] <= w_in[i];
                     g_q[i] <= g_in[i];
                  end
               end
            end
            RUN: begin
               acc_w  <= sum_w;
               acc_wg <= sum_wg;
               if (last_rule) begin
                  s_w_q  <= sat_q15(sum_w);
                  s_wg_q <= sat_q15(sum_wg);
               end else begin
                  step <= step + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.S_w       = s_w_q;
   assign bus.S_wg      = s_wg_q;
   assign busy          = (state == RUN) || (state == DONE);
   assign rule_idx      = (state == RUN) ? run_idx : '0;

endmodule

// File: tb/tb_agg_seq_ctrl.sv
// tb/tb_agg_seq_ctrl.sv - directed self-checking bench for agg_seq_ctrl
module tb_agg_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        busy;
   logic [3:0]  rule_idx;
   logic [15:0] wv [9];
   logic [7:0]  gv [9];
   int          n_cmp = 0;
   int          n_err = 0;

   agg_seq_ctrl_if bus ();

   agg_seq_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .rule_idx (rule_idx)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_idx(input logic mode, input int j);
      int corners [4] = '{0, 2, 6, 8};
      if (mode) return (j < 9) ? j : 15;
      return (j < 4) ? corners[j] : 15;
   endfunction

   task automatic apply_ops(input logic mode);
      bus.reg_mode = mode;
      bus.w00 = wv[0]; bus.w01 = wv[1]; bus.w02 = wv[2];
      bus.w10 = wv[3]; bus.w11 = wv[4]; bus.w12 = wv[5];
      bus.w20 = wv[6]; bus.w21 = wv[7]; bus.w22 = wv[8];
      bus.g00 = gv[0]; bus.g01 = gv[1]; bus.g02 = gv[2];
      bus.g10 = gv[3]; bus.g11 = gv[4]; bus.g12 = gv[5];
      bus.g20 = gv[6]; bus.g21 = gv[7]; bus.g22 = gv[8];
   endtask

   task automatic load_ramp();
      for (int i = 0; i < 9; i++) begin
         wv[i] = 16'((i + 1) * 1000);
         gv[i] = 8'((i + 1) * 10);
      end
   endtask

   task automatic do_accept(input string tag);
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check_eq({tag, "_busy"}, busy, 1);
   endtask

   task automatic wait_result(input string tag, input logic mode, input int lat,
                              input logic [15:0] sw, input logic [15:0] swg);
      int cycles = 0;
      while (!bus.out_valid && cycles < 40) begin
         if (cycles < 9) check_eq($sformatf("%s_idx%0d", tag, cycles), rule_idx, exp_idx(mode, cycles));
         @(negedge clk);
         cycles++;
      end
      check_eq({tag, "_latency"}, cycles, lat);
      check_eq({tag, "_S_w"}, bus.S_w, sw);
      check_eq({tag, "_S_wg"}, bus.S_wg, swg);
      check_eq({tag, "_in_ready"}, bus.in_ready, 0);
      check_eq({tag, "_idx_done"}, rule_idx, 0);
   endtask

   task automatic handshake(input string tag);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_eq({tag, "_hs_out_valid"}, bus.out_valid, 0);
      check_eq({tag, "_hs_in_ready"}, bus.in_ready, 1);
   endtask

   initial begin
      int guard;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wv[i] = '0;
         gv[i] = '0;
      end
      apply_ops(1'b0);
      repeat (2) @(negedge clk);

      check_eq("rst_in_ready", bus.in_ready, 1);
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_S_w", bus.S_w, 0);
      check_eq("rst_S_wg", bus.S_wg, 0);
      check_eq("rst_rule_idx", rule_idx, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // corners of the ramp: 100+900+4900+8100
      load_ramp();
      apply_ops(1'b0);
      do_accept("m0");
      wait_result("m0", 1'b0, 4, 16'd20000, 16'd14000);
      handshake("m0");

      // full grid at max weight, per-rule product 32766
      for (int i = 0; i < 9; i++) begin
         wv[i] = 16'd32767;
         gv[i] = 8'd100;
      end
      apply_ops(1'b1);
      do_accept("m1sat");
      wait_result("m1sat", 1'b1, 9, 16'd32767, 16'd32767);
      handshake("m1sat");

      // backpressure with in_valid held through the handshake edge
      load_ramp();
      apply_ops(1'b0);
      do_accept("bp");
      wait_result("bp", 1'b0, 4, 16'd20000, 16'd14000);
      bus.in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_eq($sformatf("bp_hold%0d_out_valid", k), bus.out_valid, 1);
         check_eq($sformatf("bp_hold%0d_in_ready", k), bus.in_ready, 0);
         check_eq($sformatf("bp_hold%0d_S_w", k), bus.S_w, 20000);
         check_eq($sformatf("bp_hold%0d_S_wg", k), bus.S_wg, 14000);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_eq("bp_hs_out_valid", bus.out_valid, 0);
      check_eq("bp_hs_in_ready", bus.in_ready, 1);
      check_eq("bp_hs_no_accept", busy, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check_eq("bp_second_accept", busy, 1);
      wait_result("bp2", 1'b0, 4, 16'd20000, 16'd14000);
      handshake("bp2");

      // reset in the middle of a full-grid run
      load_ramp();
      apply_ops(1'b1);
      do_accept("rmid");
      guard = 0;
      while (rule_idx != 4'd4 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check_eq("rmid_reach_idx4", rule_idx, 4);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("rmid_in_ready", bus.in_ready, 1);
      check_eq("rmid_out_valid", bus.out_valid, 0);
      check_eq("rmid_busy", busy, 0);
      check_eq("rmid_S_w", bus.S_w, 0);
      check_eq("rmid_S_wg", bus.S_wg, 0);
      check_eq("rmid_rule_idx", rule_idx, 0);
      rst_n = 1'b1;

      // ramp over all nine rules: S_w 45000 saturates, S_wg 28500
      do_accept("m1");
      wait_result("m1", 1'b1, 9, 16'd32767, 16'd28500);
      handshake("m1");

      // mode and operand changes after accept must be ignored
      load_ramp();
      apply_ops(1'b0);
      do_accept("latch");
      bus.reg_mode = 1'b1;
      bus.w11 = 16'd30000;
      bus.w00 = 16'd0;
      wait_result("latch", 1'b0, 4, 16'd20000, 16'd14000);
      handshake("latch");

      // g above 100 clamps to full scale
      for (int i = 0; i < 9; i++) begin
         wv[i] = '0;
         gv[i] = 8'd50;
      end
      wv[0] = 16'd32767;
      gv[0] = 8'd200;
      apply_ops(1'b0);
      do_accept("clamp");
      wait_result("clamp", 1'b0, 4, 16'd32767, 16'd32766);
      handshake("clamp");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
